// File: rtl/tt_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tt_sweep_ctrl
//
// Purpose:
//   Exhaustively characterises one N_IN-input, 1-output gate netlist. Every
//   input vector is driven in ascending order. Each vector is held for SETTLE
//   cycles and then for one SAMPLE cycle, in which the gate output is captured
//   into the truth table. The finished table is compared against an expected
//   table that was latched when the sweep started. While a sweep is running,
//   this block owns the gate's input pins.
//
// Parameters:
//   N_IN    gate input count (1..6); TT_W = 2**N_IN truth-table bits
//   SETTLE  settle cycles per vector before sampling (0..255)
//
// Ports:
//   clk       clock, all state changes on the rising edge
//   rst_n     asynchronous active-low reset
//   start     sweep request, only honoured in IDLE
//   abort     cancels an in-progress sweep; beats start in IDLE
//   exp_tt    expected truth table, latched when start is accepted
//   gate_in   vector driven to the gate input pins
//   gate_out  gate output pin (synchronous to clk)
//   busy      high while a sweep is in progress
//   done      one-cycle completion pulse
//   pass      result of the last completed sweep (tt_out == latched exp_tt)
//   tt_out    captured table, bit i = gate output while gate_in == i
//
// Optional feature (macro TT_SWEEP_MISMATCH_LOG_EN):
//   mism_valid  set at the first sampled bit that differs from the expectation
//   mism_idx    vector index of that first differing bit
//   When the macro is not defined, these ports and their logic are absent.
// ---------------------------------------------------------------------------
module tt_sweep_ctrl #(
    parameter  int N_IN   = 4,
    parameter  int SETTLE = 2,
    localparam int TT_W   = 1 << N_IN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [TT_W-1:0] exp_tt,
    output logic [N_IN-1:0] gate_in,
    input  logic            gate_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [TT_W-1:0] tt_out
`ifdef TT_SWEEP_MISMATCH_LOG_EN
    ,
    output logic            mism_valid,
    output logic [N_IN-1:0] mism_idx
`endif
);

    // State encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // The index is one bit wider than a vector. This lets it hold TT_W-1 plus
    // headroom. The last vector is found by comparison, never by wrap-around.
    localparam logic [N_IN:0] LAST_IDX   = (N_IN + 1)'(TT_W - 1);
    localparam logic [7:0]    SETTLE_CNT = 8'(SETTLE);

    // With SETTLE == 0 each vector is sampled directly, with no settle phase.
    localparam logic [1:0]    ST_FIRST   = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

    logic [1:0]      r_state;
    logic [N_IN:0]   r_idx;
    logic [7:0]      r_cnt;
    logic [TT_W-1:0] r_exp;
    logic [TT_W-1:0] r_tt;
    logic [N_IN-1:0] r_gate_in;
    logic            r_busy;
    logic            r_done;
    logic            r_pass;

    logic            w_accept;
    logic            w_sample_en;
    logic            w_abort_run;
    logic            w_last;
    logic [N_IN:0]   w_idx_next;
    logic [N_IN-1:0] w_idx_lo;

    // Abort beats start in IDLE. A sample taken in the same cycle as an abort
    // is thrown away, so the sample enable is also qualified by abort.
    assign w_accept    = (r_state == ST_IDLE) && start && !abort;
    assign w_abort_run = (r_state != ST_IDLE) && abort;
    assign w_sample_en = (r_state == ST_SAMPLE) && !abort;
    assign w_last      = (r_idx == LAST_IDX);
    assign w_idx_next  = r_idx + 1'b1;
    assign w_idx_lo    = r_idx[N_IN-1:0];

    // Main sequencer.
    // - done defaults low every cycle, so it can only be a one-cycle pulse.
    // - gate_in is registered next to the index, so the gate pins change on
    //   the same edge as the index.
    // - pass is written only in DONE. It therefore keeps its old value across
    //   an abort and until the next sweep completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_exp     <= '0;
            r_tt      <= '0;
            r_gate_in <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (w_abort_run) begin
                // tt_out keeps its partial contents until the next start.
                r_state   <= ST_IDLE;
                r_idx     <= '0;
                r_cnt     <= '0;
                r_gate_in <= '0;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            r_exp     <= exp_tt;
                            r_tt      <= '0;
                            r_idx     <= '0;
                            r_gate_in <= '0;
                            r_cnt     <= SETTLE_CNT;
                            r_busy    <= 1'b1;
                            r_state   <= ST_FIRST;
                        end
                    end

                    ST_SETTLE: begin
                        // The counter is loaded with SETTLE. The count of 1 is
                        // the last settle cycle, so exactly SETTLE cycles are
                        // spent here.
                        r_cnt <= r_cnt - 8'd1;
                        if (r_cnt <= 8'd1) begin
                            r_state <= ST_SAMPLE;
                        end
                    end

                    ST_SAMPLE: begin
                        if (w_sample_en) begin
                            r_tt[w_idx_lo] <= gate_out;
                        end
                        if (w_last) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_idx     <= w_idx_next;
                            r_gate_in <= w_idx_next[N_IN-1:0];
                            r_cnt     <= SETTLE_CNT;
                            r_state   <= ST_FIRST;
                        end
                    end

                    ST_DONE: begin
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_pass    <= (r_tt == r_exp);
                        r_gate_in <= '0;
                        r_idx     <= '0;
                        r_state   <= ST_IDLE;
                    end

                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef TT_SWEEP_MISMATCH_LOG_EN
    logic            r_mism_valid;
    logic [N_IN-1:0] r_mism_idx;
    logic            w_mism_hit;

    // Compare the live gate output against the latched expectation for the
    // current vector. Only the first mismatch of a sweep is recorded.
    assign w_mism_hit = w_sample_en && (gate_out != r_exp[w_idx_lo]);

    // First-mismatch log. It is cleared when a new sweep is accepted, so after
    // done a clear mism_valid means every sampled bit matched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mism_valid <= 1'b0;
            r_mism_idx   <= '0;
        end else if (w_accept) begin
            r_mism_valid <= 1'b0;
            r_mism_idx   <= '0;
        end else if (w_mism_hit && !r_mism_valid) begin
            r_mism_valid <= 1'b1;
            r_mism_idx   <= w_idx_lo;
        end
    end

    assign mism_valid = r_mism_valid;
    assign mism_idx   = r_mism_idx;
`endif

    assign gate_in = r_gate_in;
    assign busy    = r_busy;
    assign done    = r_done;
    assign pass    = r_pass;
    assign tt_out  = r_tt;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tt_sweep_ctrl
//
// Self-checking bench for tt_sweep_ctrl. It uses two instances:
//   dutA: SETTLE = 2 (default timing)
//   dutB: SETTLE = 0 (one vector per cycle)
// Each instance drives a gate stub, which is a lookup into stubTab. Expected
// behaviour comes from arithmetic on the sweep rules:
//   - vector v is held for SETTLE+1 cycles
//   - done arrives TT_W*(SETTLE+1)+1 cycles after the accepting edge
//   - the table equals the stub table, and pass equals (stub == expected)
// ---------------------------------------------------------------------------
module tb_tt_sweep_ctrl;

    localparam int N_IN     = 4;
    localparam int TT_W     = 16;
    localparam int SETTLE_A = 2;
    localparam int SETTLE_B = 0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        startA, startB;
    logic        abortA, abortB;
    logic [15:0] expIn;
    logic [15:0] stubTab;

    logic [3:0]  gateInA, gateInB;
    logic        gateOutA, gateOutB;
    logic        busyA, busyB, doneA, doneB, passA, passB;
    logic [15:0] ttOutA, ttOutB;
`ifdef TT_SWEEP_MISMATCH_LOG_EN
    logic        mismValidA, mismValidB;
    logic [3:0]  mismIdxA, mismIdxB;
`endif

    bit          sel;
    logic [3:0]  obsGateIn;
    logic        obsBusy, obsDone, obsPass;
    logic [15:0] obsTt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Gate stubs: pure truth-table lookups of the driven vector.
    assign gateOutA = stubTab[gateInA];
    assign gateOutB = stubTab[gateInB];

    // Route the outputs of the instance under test to one set of names.
    assign obsGateIn = sel ? gateInB : gateInA;
    assign obsBusy   = sel ? busyB   : busyA;
    assign obsDone   = sel ? doneB   : doneA;
    assign obsPass   = sel ? passB   : passA;
    assign obsTt     = sel ? ttOutB  : ttOutA;

    tt_sweep_ctrl #(.N_IN(N_IN), .SETTLE(SETTLE_A)) dutA (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (startA),
        .abort    (abortA),
        .exp_tt   (expIn),
        .gate_in  (gateInA),
        .gate_out (gateOutA),
        .busy     (busyA),
        .done     (doneA),
        .pass     (passA),
        .tt_out   (ttOutA)
`ifdef TT_SWEEP_MISMATCH_LOG_EN
        ,
        .mism_valid (mismValidA),
        .mism_idx   (mismIdxA)
`endif
    );

    tt_sweep_ctrl #(.N_IN(N_IN), .SETTLE(SETTLE_B)) dutB (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (startB),
        .abort    (abortB),
        .exp_tt   (expIn),
        .gate_in  (gateInB),
        .gate_out (gateOutB),
        .busy     (busyB),
        .done     (doneB),
        .pass     (passB),
        .tt_out   (ttOutB)
`ifdef TT_SWEEP_MISMATCH_LOG_EN
        ,
        .mism_valid (mismValidB),
        .mism_idx   (mismIdxB)
`endif
    );

    // One comparison: count it, and report a failure through an immediate
    // assertion.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Advance one cycle and settle 1 time unit past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one sweep on the selected instance and check it cycle by cycle
    // against the timing rules.
    //   abortAt   >= 0: abort is seen on that edge after the accepting edge
    //   restartAt >= 0: start is pulsed again while the sweep is busy
    task automatic applyStimulus(input string tag, input bit useB,
                                 input logic [15:0] stub, input logic [15:0] expTab,
                                 input int abortAt, input int restartAt);
        int          per;
        int          lat;
        logic [15:0] partial;
        logic        prevPass;
        logic [3:0]  expGate;
        logic        expBusy;
        logic        expDone;
        int          firstMis;

        sel      = useB;
        per      = (useB ? SETTLE_B : SETTLE_A) + 1;
        lat      = TT_W * per + 1;
        stubTab  = stub;
        expIn    = expTab;
        prevPass = obsPass;
        if (useB) startB = 1'b1; else startA = 1'b1;
        tick();
        startA = 1'b0;
        startB = 1'b0;
        // Only the copy latched at start may matter from here on.
        expIn  = ~expTab;

        for (int k = 0; k <= lat + 3; k++) begin
            if (k > 0) tick();
            if (abortAt >= 0 && k >= abortAt) begin
                expGate = 4'd0; expBusy = 1'b0; expDone = 1'b0;
            end else if (k < TT_W * per) begin
                expGate = 4'(k / per); expBusy = 1'b1; expDone = 1'b0;
            end else if (k == TT_W * per) begin
                expGate = 4'(TT_W - 1); expBusy = 1'b1; expDone = 1'b0;
            end else if (k == lat) begin
                expGate = 4'd0; expBusy = 1'b0; expDone = 1'b1;
            end else begin
                expGate = 4'd0; expBusy = 1'b0; expDone = 1'b0;
            end
            checkOutput($sformatf("%s k=%0d {gate_in,busy,done}", tag, k),
                        32'({obsGateIn, obsBusy, obsDone}),
                        32'({expGate, expBusy, expDone}));

            if (abortAt >= 0) begin
                if (useB) abortB = (k == abortAt - 1); else abortA = (k == abortAt - 1);
            end
            if (restartAt >= 0) begin
                if (useB) startB = (k == restartAt); else startA = (k == restartAt);
            end
        end
        abortA = 1'b0; abortB = 1'b0; startA = 1'b0; startB = 1'b0;

        if (abortAt < 0) begin
            checkOutput({tag, " tt_out"}, 32'(obsTt), 32'(stub));
            checkOutput({tag, " pass"}, 32'(obsPass), 32'(stub == expTab));
`ifdef TT_SWEEP_MISMATCH_LOG_EN
            firstMis = -1;
            for (int i = TT_W - 1; i >= 0; i--) begin
                if (stub[i] != expTab[i]) firstMis = i;
            end
            checkOutput({tag, " mism_valid"}, 32'(useB ? mismValidB : mismValidA), 32'(firstMis >= 0));
            if (firstMis >= 0) begin
                checkOutput({tag, " mism_idx"}, 32'(useB ? mismIdxB : mismIdxA), 32'(firstMis));
            end
`else
            firstMis = 0;
`endif
        end else begin
            // Vector v is written on edge (v+1)*per; anything at or after the
            // abort edge is lost.
            partial = '0;
            for (int v = 0; v < TT_W; v++) begin
                if ((v + 1) * per < abortAt) partial[v] = stub[v];
            end
            checkOutput({tag, " partial tt_out"}, 32'(obsTt), 32'(partial));
            checkOutput({tag, " pass kept"}, 32'(obsPass), 32'(prevPass));
            firstMis = 0;
        end
    endtask

    initial begin
        logic [15:0] rStub;
        logic [15:0] rExp;

        rst_n   = 1'b0;
        startA  = 1'b0; startB = 1'b0;
        abortA  = 1'b0; abortB = 1'b0;
        expIn   = '0;
        stubTab = '0;
        sel     = 1'b0;

        // Reset, then remain idle.
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        checkOutput("reset A gate_in", 32'(gateInA), 32'd0);
        checkOutput("reset A busy",    32'(busyA),   32'd0);
        checkOutput("reset A done",    32'(doneA),   32'd0);
        checkOutput("reset A pass",    32'(passA),   32'd0);
        checkOutput("reset A tt_out",  32'(ttOutA),  32'd0);
        checkOutput("reset B gate_in", 32'(gateInB), 32'd0);
        checkOutput("reset B busy",    32'(busyB),   32'd0);
        checkOutput("reset B tt_out",  32'(ttOutB),  32'd0);

        // Matching table, then a table with a single wrong bit (bit 4).
        applyStimulus("match5215", 1'b0, 16'h5215, 16'h5215, -1, -1);
        applyStimulus("miss5205",  1'b0, 16'h5215, 16'h5205, -1, -1);

        // Abort mid-sweep after a passing sweep. pass must stay 1.
        applyStimulus("passFirst", 1'b0, 16'h0F0F, 16'h0F0F, -1, -1);
        applyStimulus("abort20",   1'b0, 16'hA5C3, 16'h0000, 20, -1);
        applyStimulus("afterAbort", 1'b0, 16'h3C96, 16'h3C96, -1, -1);

        // start together with abort in IDLE is ignored.
        sel = 1'b0;
        startA = 1'b1; abortA = 1'b1;
        tick();
        startA = 1'b0; abortA = 1'b0;
        checkOutput("start+abort idle busy", 32'(busyA), 32'd0);
        repeat (3) tick();
        checkOutput("start+abort idle done", 32'(doneA), 32'd0);

        // Repeating start while busy is ignored: one sweep, one done pulse.
        applyStimulus("restart", 1'b0, 16'h8001, 16'h8001, -1, 10);

        // SETTLE = 0 instance.
        applyStimulus("settle0", 1'b1, 16'hFFFF, 16'hFFFF, -1, -1);

        // Randomised sweeps on both instances.
        for (int i = 0; i < 6; i++) begin
            rStub = 16'($urandom);
            rExp  = ($urandom_range(0, 1) == 1) ? rStub : (rStub ^ 16'($urandom_range(1, 65535)));
            applyStimulus($sformatf("rand%0d", i), i[0], rStub, rExp, -1, -1);
        end

        // Reset asserted mid-sweep, between clock edges: immediate return.
        applyStimulus("preReset", 1'b1, 16'h1234, 16'h1234, -1, -1);
        sel = 1'b1;
        stubTab = 16'hFFFF;
        expIn = 16'hFFFF;
        startB = 1'b1;
        tick();
        startB = 1'b0;
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset gate_in", 32'(gateInB), 32'd0);
        checkOutput("async reset busy",    32'(busyB),   32'd0);
        checkOutput("async reset pass",    32'(passB),   32'd0);
        checkOutput("async reset tt_out",  32'(ttOutB),  32'd0);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 25; k++) begin
            tick();
            checkOutput($sformatf("post reset k=%0d {busy,done}", k),
                        32'({busyB, doneB}), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tt_sweep_ctrl.md
Name: tt_sweep_ctrl

Overview:
Sequencer that exhaustively characterises one synthesized N-input, 1-output logic gate netlist. It drives every input vector in ascending order and waits a settle interval before sampling the gate output. It assembles the captured truth table and compares it against an expected table. It sits between the verification/host logic and a single gate instance, and owns that gate's inputs for the duration of a sweep.

Parameters:
N_IN, 4, gate input count; legal range 1..6; TT_W = 2**N_IN.
SETTLE, 2, settle cycles per vector before sampling; legal range 0..255.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  sweep request; sampled only in IDLE.
abort  input  1  cancel an in-progress sweep.
exp_tt  input  TT_W  expected truth table; latched when start is accepted.
gate_in  output  N_IN  vector driven to the gate input pins; bit k drives gate input k.
gate_out  input  1  gate output pin.
busy  output  1  high from the cycle after start is accepted until done.
done  output  1  one-cycle pulse at sweep completion.
pass  output  1  result of the last completed sweep (tt_out == latched exp_tt).
tt_out  output  TT_W  captured table; bit i = gate_out sampled while gate_in == i.

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE, gate_in=0, busy=0, done=0, pass=0, tt_out=0, vector index=0, settle counter=0, latched expected table=0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE, start=1, abort=0:
  - latch exp_tt, clear tt_out, set idx=0, load the settle counter with SETTLE.
  - go to SETTLE, or to SAMPLE if SETTLE==0.
  - gate_in=idx from the next cycle onward; busy=1.
- IDLE, start=1 and abort=1 in the same cycle: abort wins; start is ignored and no state changes.
- SETTLE: decrement the counter each cycle. When the counter is 1, go to SAMPLE next cycle. Exactly SETTLE cycles are spent in SETTLE.
- SAMPLE (one cycle): tt_out[idx] <= gate_out.
  - If idx == TT_W-1, go to DONE.
  - Otherwise idx <= idx+1, reload the counter, and go to SETTLE (or stay in SAMPLE if SETTLE==0).
  - gate_in changes together with idx.
- DONE (one cycle): done=1, busy=0, pass <= (tt_out == latched exp), gate_in <= 0, then go to IDLE.
- Latency: done is high exactly TT_W*(SETTLE+1)+1 cycles after the edge that accepted start. For N_IN=4, SETTLE=2 this is 49.
- The index counter is N_IN+1 bits wide to avoid wrap at TT_W-1. No overflow is allowed; the last index is detected by compare, not by wrap.
- start while busy or in DONE: ignored; no queuing.
- abort in SETTLE/SAMPLE/DONE: next state IDLE. busy=0, gate_in=0, no done pulse, pass retains its previous value. tt_out keeps its partial contents until the next start.
- A sample in the same cycle as abort is discarded.
- Reset mid-sweep: all outputs return to reset values immediately; no done pulse.
- gate_out is assumed synchronous to clk. It is sampled only in SAMPLE; its value in all other states is don't-care.
- pass and tt_out stay stable between done and the next accepted start.

Optional Feature:
Macro TT_SWEEP_MISMATCH_LOG_EN.
- Defined: adds outputs mism_valid (1 bit) and mism_idx (N_IN bits). Both are cleared at reset and at start acceptance.
- On the first SAMPLE where gate_out != latched exp[idx]: mism_valid <= 1 and mism_idx <= idx. Later mismatches do not update them.
- mism_valid==0 after done implies pass==1.
- Not defined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle for 10 cycles -> gate_in=0, busy=0, done=0, pass=0, tt_out=0x0000.
- Gate stub with table 0x5215, exp_tt=0x5215, N_IN=4, SETTLE=2, start pulse -> gate_in steps 0..15, each held 3 cycles; done pulses 49 cycles after start; tt_out=0x5215; pass=1.
- Same stub, exp_tt=0x5205 -> tt_out=0x5215, pass=0. With TT_SWEEP_MISMATCH_LOG_EN: mism_valid=1, mism_idx=4.
- abort asserted at cycle 20 of a sweep -> IDLE next cycle, busy=0, gate_in=0, no done pulse, pass unchanged. A new start then completes normally in 49 cycles.
- start re-pulsed while busy, and start+abort together in IDLE -> both ignored; the single sweep completes with one done pulse.
- SETTLE=0, stub with table 0xFFFF, exp_tt=0xFFFF -> one vector per cycle; done at cycle 17; pass=1. rst_n pulsed low mid-sweep -> outputs at reset values asynchronously.
